// File: rtl/shifter_pkg.sv
// Shared constants and types for the shifter block: datapath and amount
// widths, the load-upper-immediate shift distance, and the per-stage
// shift direction type.
package shifter_pkg;

    // Datapath width; the design is built and checked for 16 bits.
    localparam int DATA_W    = 16;

    // Two's complement shift-amount width, log2(DATA_W) + 1.
    localparam int AMT_W     = 5;

    // Fixed left shift applied by load-upper-immediate.
    localparam int LUI_SHIFT = 8;

    // Direction of a single barrel stage.
    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } shift_dir_e;

endpackage : shifter_pkg

// File: rtl/shifter_if.sv
// Operand / amount / result bundle for the shifter.
// There is no handshake: the slave samples in, RLamount and lui on every
// rising clock edge and presents the registered result on out one cycle
// later, accepting a new operand every cycle.
interface shifter_if #(
    parameter int DATA_W = shifter_pkg::DATA_W,
    parameter int AMT_W  = shifter_pkg::AMT_W
);

    logic [DATA_W-1:0] in;
    logic [AMT_W-1:0]  RLamount;
    logic              lui;
    logic [DATA_W-1:0] out;

    // Side that supplies operands and consumes results.
    modport master (
        output in,
        output RLamount,
        output lui,
        input  out
    );

    // Side that performs the shift (the shifter itself).
    modport slave (
        input  in,
        input  RLamount,
        input  lui,
        output out
    );

endinterface : shifter_if

// File: rtl/shifter_stage.sv
// One level of the logarithmic barrel shifter: when enabled, shifts the
// word by the fixed distance SHIFT in the selected direction, zero-filling
// the vacated bits; when disabled, passes the word through unchanged.
module shifter_stage
    import shifter_pkg::*;
#(
    parameter int DATA_W = shifter_pkg::DATA_W,
    parameter int SHIFT  = 1
) (
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_en,
    input  shift_dir_e        i_dir,
    output logic [DATA_W-1:0] o_data
);

    // Conditional fixed-distance logical shift; bits pushed out are lost.
    always_comb begin
        o_data = i_data;
        if (i_en) begin
            if (i_dir == DIR_RIGHT) begin
                o_data = i_data >> SHIFT;
            end else begin
                o_data = i_data << SHIFT;
            end
        end
    end

endmodule : shifter_stage

// File: rtl/shifter.sv
// Registered logical barrel shifter with a signed shift amount
// (positive = left, negative = right) and a load-upper-immediate override.
// Result appears on out one clock after its inputs are sampled.
module shifter
    import shifter_pkg::*;
#(
    parameter int DATA_W = shifter_pkg::DATA_W,
    parameter int AMT_W  = shifter_pkg::AMT_W
) (
    input  logic      clk,
    input  logic      rst_n,
    shifter_if.slave  bus
);

    // Sign / magnitude of the requested shift.
    logic              w_neg;
    shift_dir_e        w_dir;
    logic [AMT_W-1:0]  w_mag;

    // Word entering each barrel level; index AMT_W is the barrel output.
    logic [DATA_W-1:0] w_stage [0:AMT_W];

    logic [DATA_W-1:0] w_lui;
    logic [DATA_W-1:0] w_next;
    logic [DATA_W-1:0] r_out;

    // Amount decode: a left shift only ever uses the low AMT_W-1 bits, so
    // the top barrel level is reached solely by a right shift of DATA_W
    // (amount = most negative value), which clears the word.
    always_comb begin
        w_neg = bus.RLamount[AMT_W-1];
        w_dir = DIR_LEFT;
        w_mag = {1'b0, bus.RLamount[AMT_W-2:0]};
        if (w_neg) begin
            w_dir = DIR_RIGHT;
            w_mag = ~bus.RLamount + {{(AMT_W-1){1'b0}}, 1'b1};
        end
    end

    assign w_stage[0] = bus.in;

    // Barrel levels 1, 2, 4, 8, 16: each enabled by one magnitude bit.
    for (genvar k = 0; k < AMT_W; k++) begin : g_level
        shifter_stage #(
            .DATA_W (DATA_W),
            .SHIFT  (1 << k)
        ) u_stage (
            .i_data (w_stage[k]),
            .i_en   (w_mag[k]),
            .i_dir  (w_dir),
            .o_data (w_stage[k+1])
        );
    end

    // Load-upper-immediate takes precedence over any shift amount.
    always_comb begin
        w_lui  = bus.in << LUI_SHIFT;
        w_next = w_stage[AMT_W];
        if (bus.lui) begin
            w_next = w_lui;
        end
    end

    // Output register: cleared at once by reset, otherwise loads every edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= '0;
        end else begin
            r_out <= w_next;
        end
    end

    assign bus.out = r_out;

endmodule : shifter

// File: tb/tb_shifter.sv
// Bench for the shifter: directed vector table, a back-to-back pipelined
// sequence, randomized traffic against an arithmetic reference model, and
// asynchronous reset behaviour.
module tb_shifter;

    logic clk;
    logic rst_n;

    int n_checks;
    int n_errors;

    logic [15:0] exp_q[$];

    shifter_if #(.DATA_W(16), .AMT_W(5)) bus ();

    shifter #(
        .DATA_W (16),
        .AMT_W  (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [15:0] d;
        logic [4:0]  a;
        logic        l;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl [14];

    // Clock: period 10, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at time %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain arithmetic on the signed amount.
    function automatic logic [15:0] model(input logic [15:0] d, input logic [4:0] a, input logic l);
        longint v;
        int     s;
        longint r;
        v = longint'(d);
        s = int'($signed(a));
        if (l) begin
            r = (v % 256) * 256;
        end else if (s >= 0) begin
            r = (v * (longint'(1) << s)) % 65536;
        end else begin
            r = v / (longint'(1) << (-s));
        end
        return 16'(r);
    endfunction

    task automatic drive(input logic [15:0] d, input logic [4:0] a, input logic l);
        bus.in       = d;
        bus.RLamount = a;
        bus.lui      = l;
    endtask

    // One pipelined cycle: check the result due now, then launch a new input.
    task automatic pipe_cycle(input logic [15:0] d, input logic [4:0] a, input logic l);
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            check("pipe", bus.out, exp_q.pop_front());
        end
        drive(d, a, l);
        exp_q.push_back(model(d, a, l));
    endtask

    task automatic pipe_drain();
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            check("pipe_last", bus.out, exp_q.pop_front());
        end
        check("pipe_empty", 16'(exp_q.size()), 16'd0);
    endtask

    initial begin
        logic [4:0] seq_a [8];
        logic       seq_l [8];

        n_checks = 0;
        n_errors = 0;

        tbl[0]  = '{16'h8001, 5'b00011, 1'b0, 16'h0008};
        tbl[1]  = '{16'h8001, 5'b00110, 1'b0, 16'h0040};
        tbl[2]  = '{16'h8001, 5'b01101, 1'b0, 16'h2000};
        tbl[3]  = '{16'h8001, 5'b10010, 1'b0, 16'h0002};
        tbl[4]  = '{16'h8001, 5'b10111, 1'b0, 16'h0040};
        tbl[5]  = '{16'h8001, 5'b11001, 1'b0, 16'h0100};
        tbl[6]  = '{16'h8001, 5'b11001, 1'b1, 16'h0100};
        tbl[7]  = '{16'h8001, 5'b00111, 1'b1, 16'h0100};
        tbl[8]  = '{16'h8001, 5'b01001, 1'b1, 16'h0100};
        tbl[9]  = '{16'h8001, 5'b10101, 1'b1, 16'h0100};
        tbl[10] = '{16'hFFFF, 5'b00000, 1'b0, 16'hFFFF};
        tbl[11] = '{16'hFFFF, 5'b01111, 1'b0, 16'h8000};
        tbl[12] = '{16'hFFFF, 5'b10000, 1'b0, 16'h0000};
        tbl[13] = '{16'hFFFF, 5'b11111, 1'b0, 16'h7FFF};

        // Reset phase
        rst_n = 1'b0;
        drive(16'h1234, 5'b00001, 1'b0);
        #12;
        check("reset_out", bus.out, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table: each result one edge after its inputs
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(tbl[i].d, tbl[i].a, tbl[i].l);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), bus.out, tbl[i].exp);
        end

        // Back-to-back amount changes on consecutive cycles
        seq_a = '{5'b00011, 5'b00110, 5'b01101, 5'b10010, 5'b10111, 5'b11001, 5'b00111, 5'b10000};
        seq_l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++) begin
            pipe_cycle(16'h8001, seq_a[i], seq_l[i]);
        end
        pipe_drain();

        // Randomized traffic against the reference model
        for (int i = 0; i < 300; i++) begin
            pipe_cycle(16'($urandom_range(0, 65535)),
                       5'($urandom_range(0, 31)),
                       ($urandom_range(0, 7) == 0));
        end
        pipe_drain();

        // Asynchronous reset between edges, pending result discarded
        @(negedge clk);
        drive(16'h8001, 5'b11001, 1'b1);
        @(posedge clk);
        #1;
        check("rst_pre", bus.out, 16'h0100);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_immediate", bus.out, 16'h0000);
        drive(16'hFFFF, 5'b00000, 1'b0);
        @(posedge clk);
        #1;
        check("rst_hold", bus.out, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_release", bus.out, 16'h0000);
        @(posedge clk);
        #1;
        check("rst_first_edge", bus.out, 16'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_shifter

// File: doc/shifter.md
SHIFTER -- requirements
Module: shifter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning datapath width; only 16 is required to be supported.
REQ-002 The block SHALL have parameter AMT_W, default 5, meaning shift-amount width (two's complement), equal to log2(DATA_W)+1.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port in, input, DATA_W bits: operand to be shifted.
REQ-006 The block SHALL have port RLamount, input, AMT_W bits: signed shift amount; positive = left, negative = right.
REQ-007 The block SHALL have port lui, input, 1 bit: load-upper-immediate select; overrides RLamount when 1.
REQ-008 The block SHALL have port out, output, DATA_W bits: registered shift result.

Function
REQ-009 When lui=0 and RLamount >= 0 (MSB 0), next out SHALL be in logically shifted left by RLamount[3:0], zero-filled, with bits beyond bit 15 discarded.
REQ-010 When lui=0 and RLamount < 0 (MSB 1), next out SHALL be in logically shifted right by the magnitude (-RLamount, range 1..16), zero-filled with no sign extension.
REQ-011 RLamount = 5'b10000 (-16) SHALL produce 16'h0000; RLamount = 0 SHALL pass in unchanged.
REQ-012 When lui=1, next out SHALL be {in[7:0], 8'h00} regardless of RLamount.
REQ-013 The shift result SHALL be computed combinationally from in, RLamount and lui, and captured into out on every rising clk edge.
REQ-014 Latency SHALL be exactly 1 cycle: inputs sampled at edge N appear on out after edge N, with no stall, no handshake and a throughput of one result per cycle.
REQ-015 There SHALL be no rotate and no arithmetic shift mode, and bits shifted out SHALL be lost.
REQ-016 The combinational shift SHALL be implemented as a logarithmic barrel shifter (stages 1, 2, 4, 8, plus a 16 stage for the right-shift-by-16 case), not as a 32-way case statement.

Reset
REQ-017 Assertion of rst_n=0 SHALL immediately force out to 16'h0000, independent of clk.
REQ-018 While rst_n=0, out SHALL hold 16'h0000, and the first rising edge after deassertion SHALL load the computed result.
REQ-019 Reset asserted mid-operation SHALL discard the pending result, with no partial update.

Structure
REQ-020 DATA_W, AMT_W and the LUI shift constant (8) SHALL live in a shared package, shifter_pkg.
REQ-021 One sub-module, shifter_stage, SHALL implement a single conditional shift-by-2^k stage (direction and enable inputs) and be instantiated once per barrel level.
REQ-022 The top level SHALL contain the amount decode (sign / magnitude), the lui mux and the output register only.

Verification
REQ-023 With in=16'h8001, lui=0, the bench SHALL check RLamount=5'b00011 -> out=16'h0008, 5'b00110 -> 16'h0040 and 5'b01101 -> 16'h2000, each one cycle later.
REQ-024 With in=16'h8001, lui=0, the bench SHALL check RLamount=5'b10010 -> 16'h0002, 5'b10111 -> 16'h0040 and 5'b11001 -> 16'h0100.
REQ-025 With in=16'h8001, lui=1, the bench SHALL check that RLamount in {11001, 00111, 01001, 10101} -> out=16'h0100 in every case.
REQ-026 The bench SHALL check boundaries with in=16'hFFFF: RLamount=0 -> 16'hFFFF, 5'b01111 -> 16'h8000, 5'b10000 -> 16'h0000 and 5'b11111 -> 16'h7FFF.
REQ-027 The bench SHALL check reset: with out=16'h0100, dropping rst_n between edges gives out=16'h0000 immediately, and after release the next edge gives the computed value.
REQ-028 The bench SHALL check back-to-back changes of RLamount on consecutive cycles, requiring each result exactly one cycle after its input with no lost or repeated values.
